// File: rtl/gnr_node_lut.sv
// rtl/gnr_node_lut.sv - LUT-driven Boolean network node with slow/fast trajectory copies
module gnr_node_lut #(
    parameter int              K        = 4,
    parameter int              SLOW_DIV = 2,
    parameter logic [2**K-1:0] LUT_INIT = {{(2**K-1){1'b1}}, 1'b0},
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_nos,
    input  logic             init_state,
    input  logic             start_s0,
    input  logic             start_s1,
    input  logic [K-1:0]     in_s0,
    input  logic [K-1:0]     in_s1,
    input  logic             cfg_we,
    input  logic [K-1:0]     cfg_addr,
    input  logic             cfg_bit,
    output logic             s0,
    output logic             s1,
    output logic             node_s0,
    output logic             node_s1,
    output logic             agree,
    output logic [CNT_W-1:0] flip_cnt
);

    localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

    logic [2**K-1:0] r_lut;
    logic            r_s0;
    logic            r_s1;
    logic [DIV_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] r_flip_cnt;

    logic w_next0;
    logic w_next1;
    logic w_flip;
    logic w_cnt_sat;

    // Lookups read the registered table, so a same-cycle cfg write is not yet visible.
    assign w_next0   = r_lut[in_s0];
    assign w_next1   = r_lut[in_s1];
    assign w_flip    = (w_next1 != r_s1);
    assign w_cnt_sat = &r_flip_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut      <= LUT_INIT;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_div_cnt  <= '0;
            r_flip_cnt <= '0;
        end else begin
            if (cfg_we) begin
                r_lut[cfg_addr] <= cfg_bit;
            end
            if (reset_nos) begin
                r_s0       <= init_state;
                r_s1       <= init_state;
                r_div_cnt  <= DIV_LAST;
                r_flip_cnt <= '0;
            end else begin
                if (start_s0) begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_s0      <= w_next0;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                if (start_s1) begin
                    r_s1 <= w_next1;
                    if (w_flip && !w_cnt_sat) begin
                        r_flip_cnt <= r_flip_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign s0       = r_s0;
    assign s1       = r_s1;
    assign node_s0  = r_s0;
    assign node_s1  = r_s1;
    assign agree    = (r_s0 == r_s1);
    assign flip_cnt = r_flip_cnt;

endmodule
